// File: rtl/image_min_max_finder.sv
// image_min_max_finder: scans one ROWS x COLS frame of unsigned pixels over a
// valid/ready handshake and publishes the frame minimum and maximum. The
// published results stay stable until the next frame completes.
module image_min_max_finder #(
  parameter int DATA_WIDTH = 8,
  parameter int ROWS       = 128,
  parameter int COLS       = 128
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  pix_valid_i,
  input  logic [DATA_WIDTH-1:0] pix_data_i,
  output logic                  pix_ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] min_val_o,
  output logic [DATA_WIDTH-1:0] max_val_o,
  output logic                  flat_o
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         col_cnt_q, col_cnt_d;
  logic [RW-1:0]         row_cnt_q, row_cnt_d;
  logic [DATA_WIDTH-1:0] run_min_q, run_min_d;
  logic [DATA_WIDTH-1:0] run_max_q, run_max_d;
  logic [DATA_WIDTH-1:0] min_val_q, min_val_d;
  logic [DATA_WIDTH-1:0] max_val_q, max_val_d;
  logic                  flat_q, flat_d;
  logic                  pix_ready_q, pix_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  accept_s;
  logic                  first_s;
  logic                  last_s;
  logic [DATA_WIDTH-1:0] cand_min_s;
  logic [DATA_WIDTH-1:0] cand_max_s;

  assign accept_s = pix_valid_i && pix_ready_q;
  assign first_s  = (col_cnt_q == {CW{1'b0}}) && (row_cnt_q == {RW{1'b0}});
  assign last_s   = (col_cnt_q == COL_LAST) && (row_cnt_q == ROW_LAST);

  // Running min/max including the current pixel; the first pixel of a frame
  // replaces whatever the running registers hold from an earlier frame.
  always_comb begin
    cand_min_s = run_min_q;
    cand_max_s = run_max_q;
    if (first_s) begin
      cand_min_s = pix_data_i;
      cand_max_s = pix_data_i;
    end else begin
      if (pix_data_i < run_min_q) begin
        cand_min_s = pix_data_i;
      end else begin
        cand_min_s = run_min_q;
      end
      if (pix_data_i > run_max_q) begin
        cand_max_s = pix_data_i;
      end else begin
        cand_max_s = run_max_q;
      end
    end
  end

  // Next-state logic: frame FSM, raster counters, running and published stats.
  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    row_cnt_d = row_cnt_q;
    run_min_d = run_min_q;
    run_max_d = run_max_q;
    min_val_d = min_val_q;
    max_val_d = max_val_q;
    flat_d    = flat_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d   = ST_SCAN;
          col_cnt_d = {CW{1'b0}};
          row_cnt_d = {RW{1'b0}};
        end else begin
          state_d = state_q;
        end
      end
      ST_SCAN: begin
        if (accept_s) begin
          run_min_d = cand_min_s;
          run_max_d = cand_max_s;
          if (last_s) begin
            state_d   = ST_DONE;
            col_cnt_d = {CW{1'b0}};
            row_cnt_d = {RW{1'b0}};
            min_val_d = cand_min_s;
            max_val_d = cand_max_s;
            flat_d    = (cand_min_s == cand_max_s);
          end else if (col_cnt_q == COL_LAST) begin
            col_cnt_d = {CW{1'b0}};
            row_cnt_d = row_cnt_q + RW'(1);
          end else begin
            col_cnt_d = col_cnt_q + CW'(1);
          end
        end else begin
          state_d = ST_SCAN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    pix_ready_d = (state_d == ST_SCAN);
    busy_d      = (state_d == ST_SCAN);
    done_d      = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      col_cnt_q   <= {CW{1'b0}};
      row_cnt_q   <= {RW{1'b0}};
      run_min_q   <= {DATA_WIDTH{1'b0}};
      run_max_q   <= {DATA_WIDTH{1'b0}};
      min_val_q   <= {DATA_WIDTH{1'b0}};
      max_val_q   <= {DATA_WIDTH{1'b0}};
      flat_q      <= 1'b0;
      pix_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_cnt_q   <= col_cnt_d;
      row_cnt_q   <= row_cnt_d;
      run_min_q   <= run_min_d;
      run_max_q   <= run_max_d;
      min_val_q   <= min_val_d;
      max_val_q   <= max_val_d;
      flat_q      <= flat_d;
      pix_ready_q <= pix_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pix_ready_o = pix_ready_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign min_val_o   = min_val_q;
  assign max_val_o   = max_val_q;
  assign flat_o      = flat_q;

endmodule

// File: doc/image_min_max_finder.md
# image_min_max_finder

Streaming statistics stage placed directly upstream of the pixel normalizer. It accepts one frame of ROWS×COLS unsigned pixels over a valid/ready handshake and tracks the running minimum and maximum. At end of frame it publishes `min_val`/`max_val` and a level `done`, which drive the normalizer's `min_val`, `max_val` and start condition. Published results stay stable while the next frame is scanned.

## Interface
- `DATA_WIDTH`, 8, pixel width (unsigned)
- `ROWS`, 128, rows per frame (≥1)
- `COLS`, 128, columns per frame (≥1)

- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  one clock; reset is synchronous and active-high
- `start`  in  1  begin a frame scan; sampled in IDLE and DONE, ignored in SCAN
- `pix_valid`  in  1  upstream pixel valid
- `pix_data`  in  DATA_WIDTH  pixel value, raster order (row-major)
- `pix_ready`  out  1  block can accept; high only in SCAN
- `busy`  out  1  high in SCAN
- `done`  out  1  level, high in DONE; results valid
- `min_val`  out  DATA_WIDTH  published frame minimum
- `max_val`  out  DATA_WIDTH  published frame maximum
- `flat`  out  1  published `min_val == max_val` (normalizer outputs all zero)

## Operation
- States: IDLE, SCAN, DONE.
  - IDLE: `start`=1 → SCAN.
  - SCAN: accept pixels; on accept of pixel ROWS*COLS → DONE. `start` ignored.
  - DONE: `start`=1 → SCAN (clears `done`); otherwise hold.
- Accept = `pix_valid && pix_ready`. `pix_data` is ignored on non-accept cycles. Upstream may deassert `pix_valid` at any time; there is no timeout.
- Counters `col_cnt` (0..COLS-1) and `row_cnt` (0..ROWS-1), width `max(1,$clog2(N))`.
  - Counters advance only on accept. `col_cnt` wraps to 0 and increments `row_cnt`.
  - Both counters cleared on entry to SCAN.
  - Last pixel = `row_cnt==ROWS-1 && col_cnt==COLS-1` at accept.
- Running registers `run_min`/`run_max`:
  - First accepted pixel of a frame (counters both 0) loads both with `pix_data`. Stale values from a previous frame are never compared.
  - Later accepts: `run_min` ← `pix_data` if `pix_data < run_min`; `run_max` ← `pix_data` if `pix_data > run_max`. Unsigned comparison; ties leave the register unchanged.
- Publish on the last-pixel accept:
  - `min_val`/`max_val` ← final values including the last pixel, i.e. the combinational min/max of `run_*` and `pix_data`.
  - `flat` ← equality of those two values.
- Published outputs change only at publish or reset. During a rescan after DONE they keep the previous frame's result.
- ROWS=COLS=1: the single pixel is both min and max; `flat`=1.

## Timing
- Reset values: state IDLE, `pix_ready`=0, `busy`=0, `done`=0, `min_val`=0, `max_val`=0, `flat`=0, counters 0, `run_*` 0.
- Reset asserted mid-SCAN or in DONE:
  - Next cycle is IDLE with all reset values.
  - The partial frame is discarded and published results are cleared.
- `start` high at cycle t (IDLE/DONE) → cycle t+1: SCAN, `pix_ready`=1, `busy`=1, `done`=0.
- Throughput 1 pixel/cycle. Nth accept (N=ROWS*COLS) at cycle k → cycle k+1:
  - DONE, `done`=1, `pix_ready`=0, `busy`=0.
  - New `min_val`/`max_val`/`flat` visible.
- Minimum start-to-done latency: N+1 cycles.
- `pix_ready` is registered, with no combinational path from `pix_valid`.
- `start` and `reset` in the same cycle: reset wins.
- `pix_valid` outside SCAN: no accept, no state change.

## Test plan
- Reset, then stream 2×2 frame {10,200,3,77} back-to-back (ROWS=COLS=2) → `done` rises exactly 5 cycles after `start`; `min_val`=3, `max_val`=200, `flat`=0.
- Frame all pixels 0x55, with `pix_valid` randomly gapped → `min_val`=`max_val`=0x55, `flat`=1; accept count exactly N; `pix_ready` low after last accept.
- Extremes: first pixel 255, last pixel 0, others 128 → `min_val`=0, `max_val`=255. Confirms first-pixel load and last-pixel inclusion in publish.
- Two consecutive frames (min/max 3/200, then 50/60), `start` pulsed in DONE → during second scan outputs still 3/200 with `done`=0; after completion 50/60. `start` pulsed mid-SCAN is ignored (accept count unchanged).
- `reset` asserted after 2 of 4 pixels → next cycle IDLE, `min_val`=`max_val`=0, `done`=0. A fresh frame {9,9,9,1} then gives 1/9.
- ROWS=COLS=1 build: single pixel 42 → `done` 2 cycles after `start`, `min_val`=`max_val`=42, `flat`=1.
